tile_job_sender: RTL and testbench
==================================

Name: tile_job_sender

Overview:
Transmit end of the tile-solver job input stream. Holds one job's c_real/c_imag limbs in a local limb store, written by the host. On a start pulse it serialises the job into the typed 32-bit word stream the tile solver consumes: bits [31:29] carry the word type, bits [28:0] the payload. Sits between the host/command interface and a tile solver's in_valid/in_data/in_ready/in_end_of_stream port.

Parameters:
LIMB_INDEX_BITS, 6, log2 of limb-store depth per component (64 limbs real, 64 imag)
LIMB_SIZE_BITS, 8, limb width; legal range 1..29; zero-extended into payload [28:0]

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  limb-store write strobe
wr_sel  in  1  0 = c_real store, 1 = c_imag store
wr_index  in  LIMB_INDEX_BITS  limb index
wr_data  in  LIMB_SIZE_BITS  limb value
wr_err  out  1  one-cycle pulse: write dropped because busy
start  in  1  job start pulse
start_addr  in  29  output address payload
start_zoom  in  29  zoom-level payload
start_num_limbs  in  LIMB_INDEX_BITS+1  limbs per component
busy  out  1  job in progress
done  out  1  one-cycle pulse after the END word is accepted
out_valid  out  1  stream word valid
out_data  out  32  {type[2:0], payload[28:0]}
out_ready  in  1  sink ready
out_end_of_stream  out  1  high only on the END word

Behaviour:
- Reset: busy=0, done=0, wr_err=0, out_valid=0, out_data=0, out_end_of_stream=0, state IDLE. Limb store is not cleared. Reset mid-stream aborts the job: out_valid low the cycle after reset is sampled, no done pulse.
- Types: 0 ADDR, 1 ZOOM, 2 REAL limb, 3 IMAG limb, 4 END (payload 0, out_end_of_stream=1), 5 CSUM (optional feature only).
- Handshake: transfer when out_valid && out_ready. While out_valid && !out_ready, out_data and out_end_of_stream are held stable. out_valid never drops without a transfer except on reset. Outputs are registered; one word per cycle at full throughput.
- States: IDLE -> ADDR -> ZOOM -> REAL -> IMAG -> END -> IDLE. Each state advances on a transfer. REAL and IMAG each emit indices 0..N-1 in ascending order from the matching store.
- start is sampled only in IDLE and ignored while busy. Capture addr, zoom and num_limbs. busy=1 and out_valid=1 with the ADDR word on the next cycle.
- N = start_num_limbs, clamped to 2^LIMB_INDEX_BITS. N=0 skips REAL and IMAG: ADDR, ZOOM, END.
- On the END transfer: next cycle state=IDLE, busy=0, done=1 for one cycle. A start in that done cycle is accepted.
- Limb writes are accepted only in IDLE. A write while busy is dropped and wr_err pulses the next cycle. A write and a start in the same IDLE cycle: the write lands first, and the job sees the new value.
- Latency, zero backpressure: start to first word 1 cycle; job = 2N+3 words; done asserts 1 cycle after the last transfer.

Optional Feature:
TILE_SENDER_CHECKSUM_EN:
- Defined: a CSUM word (type 5) is inserted between the last IMAG word (or ZOOM when N=0) and END. Its payload is the XOR of all emitted limb payloads, zero-extended; the value is 0 when N=0. Job length is 2N+4 words.
- Undefined: no CSUM state or logic.

Test Plan:
- Write real {3,4,5}, imag {6,7,8}; start addr=1, zoom=2, N=3, out_ready=1 -> words 0x00000001, 0x20000002, 0x40000003, 0x40000004, 0x40000005, 0x60000006, 0x60000007, 0x60000008, 0x80000000 (eos=1). done pulses 1 cycle after the final word; 9 consecutive valid cycles.
- Same job, out_ready low for 3 cycles while 0x60000007 is presented -> word held stable; no loss or duplication; sequence identical.
- start with N=0, addr=0x1FFFFFFF, zoom=0 -> 0x1FFFFFFF, 0x20000000, 0x80000000 with eos; done.
- wr_en while busy -> wr_err pulse; a second job with the same limbs streams the original values. A start while busy is ignored, so exactly one END word is produced.
- Reset asserted during the REAL phase -> out_valid=0 and busy=0 next cycle; no done. A new start streams a complete, correct job from ADDR.
- With TILE_SENDER_CHECKSUM_EN and the first job -> 0xA000000B is inserted before 0x80000000; done after 10 words.

Source files
------------

// File: rtl/tile_job_sender.sv
`default_nettype none
// ============================================================================
// Module   : tile_job_sender
// Brief    : Transmit end of the tile-solver job input stream. Holds one job's
//            c_real/c_imag limbs in a local store and, on start, serialises
//            the job as typed 32-bit words {type[2:0], payload[28:0]}:
//            ADDR, ZOOM, REAL x N, IMAG x N, [CSUM], END.
//            Optional feature macro: TILE_SENDER_CHECKSUM_EN inserts a CSUM
//            word (XOR of all limb payloads) just before END.
// Revision : 1.0 - initial release
// ============================================================================
module tile_job_sender #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [LIMB_INDEX_BITS-1:0] wr_index,
    input  logic [LIMB_SIZE_BITS-1:0]  wr_data,
    output logic                       wr_err,
    input  logic                       start,
    input  logic [28:0]                start_addr,
    input  logic [28:0]                start_zoom,
    input  logic [LIMB_INDEX_BITS:0]   start_num_limbs,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    output logic [31:0]                out_data,
    input  logic                       out_ready,
    output logic                       out_end_of_stream
);

    localparam int c_depth = 1 << LIMB_INDEX_BITS;
    localparam logic [LIMB_INDEX_BITS:0] c_max_n = {1'b1, {LIMB_INDEX_BITS{1'b0}}};

    // Word type codes carried in out_data[31:29]
    localparam logic [2:0] c_ty_addr = 3'd0;
    localparam logic [2:0] c_ty_zoom = 3'd1;
    localparam logic [2:0] c_ty_real = 3'd2;
    localparam logic [2:0] c_ty_imag = 3'd3;
    localparam logic [2:0] c_ty_end  = 3'd4;

    // State encodes which word is currently presented on the output
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_ZOOM = 3'd2;
    localparam logic [2:0] S_REAL = 3'd3;
    localparam logic [2:0] S_IMAG = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    logic [LIMB_SIZE_BITS-1:0] r_real_mem [c_depth];
    logic [LIMB_SIZE_BITS-1:0] r_imag_mem [c_depth];

    logic [2:0]                 r_state;
    logic [LIMB_INDEX_BITS:0]   r_idx;
    logic [LIMB_INDEX_BITS:0]   r_n;
    logic [28:0]                r_zoom;
    logic                       r_out_valid;
    logic [31:0]                r_out_data;
    logic                       r_eos;
    logic                       r_done;
    logic                       r_wr_err;

    logic [2:0]                 w_state_nxt;
    logic [LIMB_INDEX_BITS:0]   w_idx_nxt;
    logic                       w_valid_nxt;
    logic [31:0]                w_data_nxt;
    logic                       w_eos_nxt;
    logic                       w_done_nxt;
    logic                       w_fire;
    logic                       w_idle;
    logic [LIMB_INDEX_BITS:0]   w_idx_inc;
    logic [LIMB_INDEX_BITS:0]   w_n_clamped;
    logic                       w_last_limb;

    // Word that follows the last IMAG word (or ZOOM when N=0)
    logic [2:0]                 w_tail_state;
    logic [31:0]                w_tail_data;
    logic                       w_tail_eos;

    assign w_fire      = r_out_valid && out_ready;
    assign w_idle      = (r_state == S_IDLE);
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_last_limb = (w_idx_inc == r_n);
    assign w_n_clamped = (start_num_limbs > c_max_n) ? c_max_n : start_num_limbs;

`ifdef TILE_SENDER_CHECKSUM_EN
    localparam logic [2:0] c_ty_csum = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;

    logic [LIMB_SIZE_BITS-1:0] r_csum;
    logic [LIMB_SIZE_BITS-1:0] w_csum_nxt;
    logic                      w_limb_fire;

    // Running XOR including the limb being accepted this cycle
    assign w_limb_fire  = w_fire && ((r_state == S_REAL) || (r_state == S_IMAG));
    assign w_csum_nxt   = r_csum ^ (w_limb_fire ? r_out_data[LIMB_SIZE_BITS-1:0] : '0);
    assign w_tail_state = S_CSUM;
    assign w_tail_data  = {c_ty_csum, 29'(w_csum_nxt)};
    assign w_tail_eos   = 1'b0;

    // Checksum accumulator, cleared whenever a job is launched
    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_idle && start) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end
`else
    assign w_tail_state = S_END;
    assign w_tail_data  = {c_ty_end, 29'd0};
    assign w_tail_eos   = 1'b1;
`endif

    // Limb store writes; only accepted while idle, never cleared by reset
    always_ff @(posedge clock) begin
        if (wr_en && w_idle) begin
            if (wr_sel) begin
                r_imag_mem[wr_index] <= wr_data;
            end else begin
                r_real_mem[wr_index] <= wr_data;
            end
        end
    end

    // Next state and next output word; holds everything unless a transfer or start occurs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_out_valid;
        w_data_nxt  = r_out_data;
        w_eos_nxt   = r_eos;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ADDR;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = {c_ty_addr, start_addr};
                    w_eos_nxt   = 1'b0;
                end
            end
            S_ADDR: begin
                if (w_fire) begin
                    w_state_nxt = S_ZOOM;
                    w_data_nxt  = {c_ty_zoom, r_zoom};
                end
            end
            S_ZOOM: begin
                if (w_fire) begin
                    w_idx_nxt = '0;
                    if (r_n == '0) begin
                        w_state_nxt = w_tail_state;
                        w_data_nxt  = w_tail_data;
                        w_eos_nxt   = w_tail_eos;
                    end else begin
                        w_state_nxt = S_REAL;
                        w_data_nxt  = {c_ty_real, 29'(r_real_mem[0])};
                    end
                end
            end
            S_REAL: begin
                if (w_fire) begin
                    if (w_last_limb) begin
                        w_state_nxt = S_IMAG;
                        w_idx_nxt   = '0;
                        w_data_nxt  = {c_ty_imag, 29'(r_imag_mem[0])};
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_data_nxt = {c_ty_real, 29'(r_real_mem[w_idx_inc[LIMB_INDEX_BITS-1:0]])};
                    end
                end
            end
            S_IMAG: begin
                if (w_fire) begin
                    if (w_last_limb) begin
                        w_state_nxt = w_tail_state;
                        w_data_nxt  = w_tail_data;
                        w_eos_nxt   = w_tail_eos;
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_data_nxt = {c_ty_imag, 29'(r_imag_mem[w_idx_inc[LIMB_INDEX_BITS-1:0]])};
                    end
                end
            end
`ifdef TILE_SENDER_CHECKSUM_EN
            S_CSUM: begin
                if (w_fire) begin
                    w_state_nxt = S_END;
                    w_data_nxt  = {c_ty_end, 29'd0};
                    w_eos_nxt   = 1'b1;
                end
            end
`endif
            S_END: begin
                if (w_fire) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_data_nxt  = '0;
                    w_eos_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
                w_eos_nxt   = 1'b0;
            end
        endcase
    end

    // State, registered outputs and job parameters captured at start
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_n         <= '0;
            r_zoom      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_eos       <= 1'b0;
            r_done      <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_eos       <= w_eos_nxt;
            r_done      <= w_done_nxt;
            r_wr_err    <= wr_en && !w_idle;
            if (w_idle && start) begin
                r_n    <= w_n_clamped;
                r_zoom <= start_zoom;
            end
        end
    end

    assign busy              = !w_idle;
    assign done              = r_done;
    assign wr_err            = r_wr_err;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_end_of_stream = r_eos;

endmodule
`default_nettype wire

// File: tb/tb_tile_job_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_job_sender
// Brief    : Directed self-checking bench for tile_job_sender: nominal job,
//            backpressure hold, N=0 job, busy write/start rejection and
//            reset mid-stream abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_job_sender;

    localparam int LIMB_INDEX_BITS = 6;
    localparam int LIMB_SIZE_BITS  = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       r_wr_en;
    logic                       r_wr_sel;
    logic [LIMB_INDEX_BITS-1:0] r_wr_index;
    logic [LIMB_SIZE_BITS-1:0]  r_wr_data;
    logic                       w_wr_err;
    logic                       r_start;
    logic [28:0]                r_start_addr;
    logic [28:0]                r_start_zoom;
    logic [LIMB_INDEX_BITS:0]   r_start_num_limbs;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_out_valid;
    logic [31:0]                w_out_data;
    logic                       r_out_ready;
    logic                       w_eos;

    int n_checks = 0;
    int n_fails  = 0;

    // Monitor state
    logic [31:0] q_data[$];
    logic        q_eos[$];
    logic [31:0] exp_q[$];
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_xfer_cyc = -1;
    int start_cyc = -1;
    int first_valid_cyc = -1;
    int valid_cnt = 0;

    tile_job_sender #(
        .LIMB_INDEX_BITS(LIMB_INDEX_BITS),
        .LIMB_SIZE_BITS (LIMB_SIZE_BITS)
    ) u_dut (
        .clock            (clk),
        .reset            (rst),
        .wr_en            (r_wr_en),
        .wr_sel           (r_wr_sel),
        .wr_index         (r_wr_index),
        .wr_data          (r_wr_data),
        .wr_err           (w_wr_err),
        .start            (r_start),
        .start_addr       (r_start_addr),
        .start_zoom       (r_start_zoom),
        .start_num_limbs  (r_start_num_limbs),
        .busy             (w_busy),
        .done             (w_done),
        .out_valid        (w_out_valid),
        .out_data         (w_out_data),
        .out_ready        (r_out_ready),
        .out_end_of_stream(w_eos)
    );

    always #5 clk = ~clk;

    // Record transfers and pulses at the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (w_out_valid) valid_cnt = valid_cnt + 1;
        if (w_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (r_start && start_cyc < 0) start_cyc = cyc;
        if (w_out_valid && r_out_ready) begin
            q_data.push_back(w_out_data);
            q_eos.push_back(w_eos);
            last_xfer_cyc = cyc;
        end
        if (w_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_limb(input logic sel, input int idx, input logic [7:0] data);
        r_wr_en    = 1'b1;
        r_wr_sel   = sel;
        r_wr_index = idx[LIMB_INDEX_BITS-1:0];
        r_wr_data  = data;
        tick();
        r_wr_en = 1'b0;
    endtask

    task automatic clear_monitor;
        q_data.delete();
        q_eos.delete();
        start_cyc       = -1;
        first_valid_cyc = -1;
        valid_cnt       = 0;
    endtask

    task automatic start_job(input logic [28:0] a, input logic [28:0] z, input int n);
        r_start           = 1'b1;
        r_start_addr      = a;
        r_start_zoom      = z;
        r_start_num_limbs = n[LIMB_INDEX_BITS:0];
        tick();
        r_start = 1'b0;
    endtask

    // Wait for a done pulse; optionally stall 3 cycles on the word 0x60000007
    task automatic wait_done(input string tag, input bit stall);
        int  d0;
        bit  stalled;
        d0 = done_cnt;
        stalled = 1'b0;
        for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            if (stall && !stalled && w_out_valid && w_out_data == 32'h6000_0007) begin
                r_out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check_val({tag, "_hold_data"}, w_out_data, 32'h6000_0007);
                    check_val({tag, "_hold_valid"}, {31'd0, w_out_valid}, 32'd1);
                end
                r_out_ready = 1'b1;
                stalled = 1'b1;
            end
            tick();
        end
        check_val({tag, "_done_seen"}, done_cnt - d0, 32'd1);
        check_val({tag, "_done_pulse_len"}, {31'd0, w_done}, 32'd0);
        check_val({tag, "_busy_after"}, {31'd0, w_busy}, 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check_val({tag, "_n_words"}, q_data.size(), exp_q.size());
        n = (q_data.size() < exp_q.size()) ? q_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_word%0d", tag, i), q_data[i], exp_q[i]);
            check_val($sformatf("%s_eos%0d", tag, i), {31'd0, q_eos[i]},
                      (i == exp_q.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic load_exp_job1;
        exp_q = '{32'h0000_0001, 32'h2000_0002, 32'h4000_0003, 32'h4000_0004,
                  32'h4000_0005, 32'h6000_0006, 32'h6000_0007, 32'h6000_0008};
`ifdef TILE_SENDER_CHECKSUM_EN
        exp_q.push_back(32'hA000_000B);
`endif
        exp_q.push_back(32'h8000_0000);
    endtask

    initial begin
        rst               = 1'b1;
        r_wr_en           = 1'b0;
        r_wr_sel          = 1'b0;
        r_wr_index        = '0;
        r_wr_data         = '0;
        r_start           = 1'b0;
        r_start_addr      = '0;
        r_start_zoom      = '0;
        r_start_num_limbs = '0;
        r_out_ready       = 1'b1;
        tick();
        tick();
        check_val("rst_busy",      {31'd0, w_busy},      32'd0);
        check_val("rst_done",      {31'd0, w_done},      32'd0);
        check_val("rst_wr_err",    {31'd0, w_wr_err},    32'd0);
        check_val("rst_out_valid", {31'd0, w_out_valid}, 32'd0);
        check_val("rst_out_data",  w_out_data,           32'd0);
        check_val("rst_eos",       {31'd0, w_eos},       32'd0);
        rst = 1'b0;
        tick();

        // Load limbs: real {3,4,5}, imag {6,7,8}
        for (int i = 0; i < 3; i++) write_limb(1'b0, i, 8'(3 + i));
        for (int i = 0; i < 3; i++) write_limb(1'b1, i, 8'(6 + i));

        // Job 1: nominal stream at full throughput
        load_exp_job1();
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        wait_done("job1", 1'b0);
        compare_stream("job1");
        check_val("job1_first_latency", first_valid_cyc - start_cyc, 32'd1);
        check_val("job1_valid_cycles", valid_cnt, exp_q.size());
        check_val("job1_done_latency", done_cyc - last_xfer_cyc, 32'd1);

        // Job 2: backpressure while 0x60000007 is presented
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        wait_done("job2", 1'b1);
        compare_stream("job2");

        // Job 3: N=0 skips the limb phases
        exp_q = '{32'h1FFF_FFFF, 32'h2000_0000};
`ifdef TILE_SENDER_CHECKSUM_EN
        exp_q.push_back(32'hA000_0000);
`endif
        exp_q.push_back(32'h8000_0000);
        clear_monitor();
        start_job(29'h1FFF_FFFF, 29'd0, 0);
        wait_done("job3", 1'b0);
        compare_stream("job3");

        // Job 4: a write and a start while busy are both dropped
        load_exp_job1();
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        r_wr_en      = 1'b1;
        r_wr_sel     = 1'b0;
        r_wr_index   = '0;
        r_wr_data    = 8'h99;
        r_start      = 1'b1;
        r_start_addr = 29'h55;
        tick();
        r_wr_en = 1'b0;
        r_start = 1'b0;
        check_val("busy_wr_err_pulse", {31'd0, w_wr_err}, 32'd1);
        tick();
        check_val("busy_wr_err_clear", {31'd0, w_wr_err}, 32'd0);
        wait_done("job4", 1'b0);
        compare_stream("job4");

        // Job 5: the dropped write must not have reached the store
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        wait_done("job5", 1'b0);
        compare_stream("job5");

        // Reset during the REAL phase aborts the job without done
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        for (int i = 0; i < 20 && !(w_out_valid && w_out_data == 32'h4000_0004); i++) tick();
        check_val("abort_reached_real", w_out_data, 32'h4000_0004);
        begin
            int d0;
            d0 = done_cnt;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_val("abort_valid", {31'd0, w_out_valid}, 32'd0);
            check_val("abort_busy",  {31'd0, w_busy},      32'd0);
            for (int i = 0; i < 5; i++) tick();
            check_val("abort_no_done", done_cnt - d0, 32'd0);
        end

        // Job 6: restart after abort streams a complete job
        clear_monitor();
        start_job(29'd1, 29'd2, 3);
        wait_done("job6", 1'b0);
        compare_stream("job6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
